// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port round-robin arbiter in front of a byte-addressed data
//            memory, with per-access range check and one-cycle responses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH = 180
) (
    input  logic        arb_clk,
    input  logic        arb_rst_n,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_instr,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_instr,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_instr,
    output logic        mem_R,
    output logic        mem_W,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] c_DEPTH_LIMIT = 33'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_port;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_instr;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_winner;
    logic [2:0]  w_size;
    logic [32:0] w_end;
    logic        w_in_range;
    logic        w_is_store;
    logic        w_access;
    logic        w_resp;
    logic        w_mem_en;

    // On a tie the port that did not win last time goes next.
    assign w_any_req = p0_req | p1_req;
    assign w_winner  = (p0_req && p1_req) ? ~r_last_grant : p1_req;

    always_comb begin
        w_size = 3'd1;
        case (r_instr)
            3'd0, 3'd3, 3'd5: w_size = 3'd1;
            3'd1, 3'd4, 3'd6: w_size = 3'd2;
            3'd2, 3'd7:       w_size = 3'd4;
            default:          w_size = 3'd1;
        endcase
    end

    // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap back into range.
    assign w_end      = {1'b0, r_addr} + {30'd0, w_size};
    assign w_in_range = (w_end <= c_DEPTH_LIMIT);
    assign w_is_store = (r_instr >= 3'd5);

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_instr      <= 3'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port       <= w_winner;
                        r_last_grant <= w_winner;
                        r_addr       <= w_winner ? p1_addr  : p0_addr;
                        r_wdata      <= w_winner ? p1_wdata : p0_wdata;
                        r_instr      <= w_winner ? p1_instr : p0_instr;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (w_in_range && !w_is_store) ? mem_rdata : 32'd0;
                    r_err   <= ~w_in_range;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode state and latched registers only, so reset clears them
    // asynchronously and no request input reaches an output.
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);
    assign w_mem_en = w_access & w_in_range;

    assign p0_gnt    = w_access & ~r_port;
    assign p1_gnt    = w_access &  r_port;

    assign p0_rvalid = w_resp & ~r_port;
    assign p1_rvalid = w_resp &  r_port;
    assign p0_rdata  = p0_rvalid ? r_rdata : 32'd0;
    assign p1_rdata  = p1_rvalid ? r_rdata : 32'd0;
    assign p0_err    = p0_rvalid & r_err;
    assign p1_err    = p1_rvalid & r_err;

    assign mem_addr  = w_mem_en ? r_addr  : 32'd0;
    assign mem_wdata = w_mem_en ? r_wdata : 32'd0;
    assign mem_instr = w_mem_en ? r_instr : 3'd0;
    assign mem_R     = w_mem_en & ~w_is_store;
    assign mem_W     = w_mem_en &  w_is_store;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed, table-driven bench for dmem_arbiter with a byte memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DEPTH = 180;

    logic        arb_clk;
    logic        arb_rst_n;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_instr, p1_instr;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_instr;
    logic        mem_R, mem_W;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .arb_clk   (arb_clk),
        .arb_rst_n (arb_rst_n),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_instr  (p0_instr),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_instr  (p1_instr),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_instr (mem_instr),
        .mem_R     (mem_R),
        .mem_W     (mem_W),
        .mem_rdata (mem_rdata)
    );

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    // Byte-addressed little-endian data memory.
    logic [7:0] mem [0:DEPTH-1];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < 32'(DEPTH)) return mem[a];
        return 8'h00;
    endfunction

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = rd_byte(mem_addr);
        b1 = rd_byte(mem_addr + 32'd1);
        b2 = rd_byte(mem_addr + 32'd2);
        b3 = rd_byte(mem_addr + 32'd3);
        mem_rdata = 32'h0;
        if (mem_R) begin
            case (mem_instr)
                3'd0: mem_rdata = {{24{b0[7]}}, b0};
                3'd1: mem_rdata = {{16{b1[7]}}, b1, b0};
                3'd2: mem_rdata = {b3, b2, b1, b0};
                3'd3: mem_rdata = {24'h0, b0};
                3'd4: mem_rdata = {16'h0, b1, b0};
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    always @(posedge arb_clk) begin
        if (mem_W) begin
            for (int k = 0; k < 4; k++) begin
                if ((mem_instr == 3'd7 || (mem_instr == 3'd6 && k < 2) || k == 0) &&
                    (mem_addr + 32'(k) < 32'(DEPTH)))
                    mem[mem_addr + 32'(k)] <= mem_wdata[8*k +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic        port;
        logic [2:0]  instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_r;
        logic        exp_w;
    } vec_t;

    task automatic drive_req(input logic port, input logic v, input logic [2:0] instr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            p0_req = v; p0_instr = instr; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = v; p1_instr = instr; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Entered just after a rising edge with the arbiter idle.
    task automatic run_access(input string tag, input vec_t v);
        int   waited;
        logic gnt;
        logic en;
        drive_req(v.port, 1'b1, v.instr, v.addr, v.wdata);
        waited = 0;
        gnt    = 1'b0;
        while (!gnt && waited < 10) begin
            @(posedge arb_clk); #1;
            waited++;
            gnt = v.port ? p1_gnt : p0_gnt;
        end
        chk({tag, " gnt_latency"}, 32'(waited), 32'd1);
        if (!gnt) begin
            drive_req(v.port, 1'b0, 3'd0, 32'd0, 32'd0);
            return;
        end
        en = v.exp_r | v.exp_w;
        chk({tag, " other_gnt"}, {31'd0, v.port ? p0_gnt : p1_gnt}, 32'd0);
        chk({tag, " mem_R_W"}, {30'd0, mem_R, mem_W}, {30'd0, v.exp_r, v.exp_w});
        chk({tag, " mem_addr"}, mem_addr, en ? v.addr : 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, en ? v.wdata : 32'd0);
        chk({tag, " mem_instr"}, {29'd0, mem_instr}, en ? {29'd0, v.instr} : 32'd0);
        drive_req(v.port, 1'b0, 3'd0, 32'd0, 32'd0);

        @(posedge arb_clk); #1;
        chk({tag, " rvalid"}, {31'd0, v.port ? p1_rvalid : p0_rvalid}, 32'd1);
        chk({tag, " rdata"}, v.port ? p1_rdata : p0_rdata, v.exp_rdata);
        chk({tag, " err"}, {31'd0, v.port ? p1_err : p0_err}, {31'd0, v.exp_err});
        chk({tag, " other_resp"},
            (v.port ? p0_rdata : p1_rdata) | {30'd0, v.port ? p0_rvalid : p1_rvalid,
                                                     v.port ? p0_err : p1_err}, 32'd0);
        chk({tag, " mem_idle_resp"}, mem_addr | mem_wdata | {27'd0, mem_instr, mem_R, mem_W}, 32'd0);

        @(posedge arb_clk); #1;
        chk({tag, " rvalid_one_cycle"}, {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    endtask

    vec_t vecs [16];

    initial begin
        int   gcount;
        int   gcyc  [4];
        logic gport [4];
        int   cyc;
        int   stray;

        vecs[0]  = '{1'b0, 3'd7, 32'd8,          32'h82345678, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'd2, 32'd8,          32'h0,        32'h82345678, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd0, 32'd11,         32'h0,        32'hFFFFFF82, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 32'd11,         32'h0,        32'h00000082, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd4, 32'd10,         32'h0,        32'h00008234, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 32'd10,         32'h0,        32'hFFFF8234, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd2, 32'd177,        32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 32'd178,        32'h0,        32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd5, 32'hFFFFFFFF,   32'h00000055, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd5, 32'd179,        32'h000000AB, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 3'd3, 32'd179,        32'h0,        32'h000000AB, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'd6, 32'd179,        32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 32'd179,        32'h0,        32'hFFFFFFAB, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 3'd7, 32'd20,         32'h11223344, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 3'd2, 32'd176,        32'h0,        32'hAB000000, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 3'd1, 32'd9,          32'h0,        32'h00003456, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        arb_rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

        repeat (3) @(posedge arb_clk);
        #1;
        chk("reset outputs",
            mem_addr | mem_wdata | p0_rdata | p1_rdata |
            {23'd0, mem_instr, mem_R, mem_W, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid},
            32'd0);
        chk("reset err", {30'd0, p0_err, p1_err}, 32'd0);
        arb_rst_n = 1'b1;

        // Both ports keep requesting from reset: grants alternate from p0.
        drive_req(1'b0, 1'b1, 3'd2, 32'd0, 32'd0);
        drive_req(1'b1, 1'b1, 3'd2, 32'd4, 32'd0);
        gcount = 0;
        cyc    = 0;
        while (gcount < 4 && cyc < 30) begin
            @(posedge arb_clk); #1;
            cyc++;
            if (p0_gnt || p1_gnt) begin
                gcyc[gcount]  = cyc;
                gport[gcount] = p1_gnt;
                gcount++;
            end
        end
        chk("rr grant count", 32'(gcount), 32'd4);
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        if (gcount == 4) begin
            chk("rr first latency", 32'(gcyc[0]), 32'd1);
            chk("rr order", {28'd0, gport[0], gport[1], gport[2], gport[3]}, 32'b0101);
            for (int i = 1; i < 4; i++)
                chk($sformatf("rr spacing %0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        repeat (3) @(posedge arb_clk);
        #1;

        for (int i = 0; i < 16; i++)
            run_access($sformatf("vec%0d", i), vecs[i]);

        // Reset during ACCESS of a store must abort it with no write or response.
        drive_req(1'b0, 1'b1, 3'd7, 32'd20, 32'hDEADBEEF);
        @(posedge arb_clk); #1;
        chk("abort gnt", {31'd0, p0_gnt}, 32'd1);
        chk("abort mem_W before", {31'd0, mem_W}, 32'd1);
        #2 arb_rst_n = 1'b0;
        #1;
        chk("abort mem_W async", {30'd0, mem_W, p0_gnt}, 32'd0);
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge arb_clk); #1;
            if (p0_rvalid || p1_rvalid || p0_gnt || p1_gnt || mem_W) stray++;
        end
        arb_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge arb_clk); #1;
            if (p0_rvalid || p1_rvalid || p0_gnt || p1_gnt) stray++;
        end
        chk("abort no response", 32'(stray), 32'd0);
        run_access("after_abort lw20",
                   '{1'b0, 3'd2, 32'd20, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 180, SHALL set the data memory size in bytes used for the range check.
REQ-002 arb_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 arb_rst_n  in  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 pN_req  in  1  (N=0,1) SHALL mark a request; it is held, with addr/wdata/instr stable, until pN_gnt.
REQ-005 pN_addr  in  32; pN_wdata  in  32 SHALL give the byte address and store data.
REQ-006 pN_instr  in  3 SHALL use the data-memory codes: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw.
REQ-007 pN_gnt  out  1 SHALL be a one-cycle acceptance pulse.
REQ-008 pN_rvalid  out  1; pN_rdata  out  32; pN_err  out  1 SHALL form a one-cycle response.
REQ-009 mem_addr  out  32; mem_wdata  out  32; mem_instr  out  3 SHALL drive the data memory.
REQ-010 mem_R  out  1; mem_W  out  1 SHALL be the memory read and write enables.
REQ-011 mem_rdata  in  32 SHALL be the memory's combinational load result.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS and RESP, and SHALL transition only in the order IDLE->ACCESS->RESP->IDLE.
REQ-013 In IDLE, when any pN_req=1, the FSM SHALL move to ACCESS and latch the winner's addr, wdata, instr and port id.
REQ-014 Arbitration SHALL be round-robin via a last_grant register: a single requester wins; on simultaneous requests the port not equal to last_grant wins.
REQ-015 The winner's pN_gnt SHALL be high for exactly the ACCESS cycle, and last_grant SHALL update to the winner.
REQ-016 Requests arriving in ACCESS or RESP SHALL wait; nothing is dropped while req is held.
REQ-017 Size SHALL be 1 for codes 0/3/5, 2 for codes 1/4/6, and 4 for codes 2/7.
REQ-018 The range check SHALL compute addr+size in 33 bits; the access is out of range when the result exceeds DEPTH.
REQ-019 In ACCESS with an in-range access, mem_addr, mem_wdata and mem_instr SHALL carry the latched values.
REQ-020 In that case, mem_R=1 for codes 0-4 and mem_W=1 for codes 5-7, so a store commits on the edge that leaves ACCESS.
REQ-021 For an in-range load, mem_rdata SHALL be captured into a response register at the edge that leaves ACCESS.
REQ-022 For an in-range store, the captured response value SHALL be 0.
REQ-023 An out-of-range access SHALL keep mem_R=mem_W=0 in ACCESS, and SHALL return err=1 with rdata=0.
REQ-024 In RESP, only the latched port SHALL drive rvalid=1 with its rdata and err; the other port's response outputs SHALL stay 0.
REQ-025 The memory outputs SHALL be 0 outside ACCESS.
REQ-026 Latency SHALL be: req seen in IDLE at cycle N, gnt at N+1, rvalid at N+2, IDLE at N+3; peak throughput is one access per 3 cycles.
REQ-027 rvalid SHALL be asserted for stores as well as loads, as write completion.
REQ-028 All outputs SHALL be registered or decoded from state and latched registers only; there SHALL be no combinational path from pN_req.

Reset
REQ-029 While arb_rst_n=0: state=IDLE, last_grant=1 (p0 wins first), all latches=0, and all outputs=0.
REQ-030 Reset asserted during ACCESS or RESP SHALL abort immediately: mem_W drops asynchronously, and no rvalid or gnt is issued for the aborted request.
REQ-031 The first request after reset release SHALL be arbitrated normally from IDLE.

Verification
REQ-032 p0 sw addr=8 wdata=0x82345678, then p0 lw addr=8 -> mem_W pulses once; second rvalid has rdata=0x82345678, err=0.
REQ-033 After REQ-032, p1 lb addr=11 -> rdata=0xFFFFFF82; lbu addr=11 -> 0x00000082; lhu addr=10 -> 0x00008234.
REQ-034 p0 and p1 requests held together from reset -> grants p0, p1, p0, p1 alternately, each 3 cycles apart.
REQ-035 p1 lw addr=177 with DEPTH=180 -> err=1, rdata=0, mem_R=0; lh addr=178 -> err=0; sb addr=0xFFFFFFFF -> err=1, mem_W=0.
REQ-036 arb_rst_n pulled low during ACCESS of sw addr=20 -> mem_W=0 immediately, no rvalid; after release, lw addr=20 returns prior contents.
